// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants and helpers for the extended Hamming (SECDED) codec.
// Supplies the code geometry functions, the power-of-two test and the error class.
package ecc_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } err_class_e;

    // True when value is a positive power of two (a Hamming parity slot).
    function automatic logic ecc_is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Smallest R with 2^R >= K + R + 1.
    function automatic int ecc_parity_bits(input int k);
        int r;
        r = 0;
        for (int i = 7; i >= 1; i--) begin
            if ((1 << i) >= k + i + 1) r = i;
        end
        return r;
    endfunction

    // Full codeword width: payload, Hamming parity and the overall parity bit.
    function automatic int ecc_cw_width(input int k);
        return k + ecc_parity_bits(k) + 1;
    endfunction

    // 1-based Hamming position of payload bit j (j-th non-power-of-two position).
    function automatic int ecc_data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < 128; p++) begin
            if (!ecc_is_pow2(p)) begin
                if (cnt == j) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/extended_hamming_stream_codec_if.sv
// extended_hamming_stream_codec_if: input and output streams of the codec.
// The codec attaches through the slave modport, the traffic source/sink through master.
interface extended_hamming_stream_codec_if
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) ();

    localparam int CW_WIDTH = ecc_cw_width(DATA_WIDTH);

    logic                in_valid;
    logic                in_ready;
    logic                in_op;
    logic [CW_WIDTH-1:0] in_data;

    logic                out_valid;
    logic                out_ready;
    logic                out_op;
    logic [CW_WIDTH-1:0] out_data;
    logic                out_err_corr;
    logic                out_err_uncorr;

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_op, out_data, out_err_corr, out_err_uncorr
    );

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_op, out_data, out_err_corr, out_err_uncorr
    );

endinterface

// File: rtl/secded_syndrome_gen.sv
// secded_syndrome_gen: combinational Hamming check-bit generator.
// Fed a payload-only word it yields the parity bits; fed a received codeword it
// yields the syndrome. o_xor_all is the XOR of every bit of the word.
module secded_syndrome_gen
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int R          = ecc_parity_bits(DATA_WIDTH),
    localparam int CW         = ecc_cw_width(DATA_WIDTH)
) (
    input  logic [CW-1:0] i_word,
    output logic [R-1:0]  o_syndrome,
    output logic          o_xor_all
);

    localparam int KR = DATA_WIDTH + R;

    // Check bit i covers every position 1..K+R whose index has bit i set.
    always_comb begin
        o_syndrome = '0;
        for (int p = 1; p <= KR; p++) begin
            for (int i = 0; i < R; i++) begin
                if (((p >> i) & 1) == 1) o_syndrome[i] = o_syndrome[i] ^ i_word[p-1];
            end
        end
    end

    assign o_xor_all = ^i_word;

endmodule

// File: rtl/extended_hamming_stream_codec.sv
// extended_hamming_stream_codec: two-stage SECDED encode/decode stream pipeline.
// Stage 1 registers the beat with its check bits, stage 2 corrects/assembles and
// registers the result. A stalled output freezes both stages.
// Optional macro ECC_ERR_COUNTERS_EN enables the saturating error counters;
// without it the counter outputs read 0 and cnt_clr is ignored.
module extended_hamming_stream_codec
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    extended_hamming_stream_codec_if.slave bus,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          corr_cnt,
    output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

    localparam int           R      = ecc_parity_bits(DATA_WIDTH);
    localparam int           KR     = DATA_WIDTH + R;
    localparam int           CW     = KR + 1;
    localparam logic [R-1:0] KR_SYN = R'(KR);

    logic                  w_stall;
    logic [CW-1:0]         w_enc_word;
    logic [CW-1:0]         w_gen_word;
    logic [R-1:0]          w_syndrome;
    logic                  w_xor_all;

    logic                  r_s1_valid;
    logic                  r_s1_op;
    logic [CW-1:0]         r_s1_word;
    logic [R-1:0]          r_s1_syn;
    logic                  r_s1_xor;

    logic [CW-1:0]         w_enc_cw;
    err_class_e            w_class;
    logic [DATA_WIDTH-1:0] w_dec_data;
    logic [CW-1:0]         w_s2_data;

    logic                  r_out_valid;
    logic                  r_out_op;
    logic [CW-1:0]         r_out_data;
    logic                  r_out_corr;
    logic                  r_out_uncorr;

    // A result that cannot leave holds the whole pipe, so input is refused.
    assign w_stall      = r_out_valid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    // Spread the payload over the non-power-of-two positions; parity slots stay 0.
    always_comb begin
        w_enc_word = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            w_enc_word[ecc_data_pos(j)-1] = bus.in_data[j];
        end
    end

    // One generator serves both directions: payload word for encode, raw codeword for decode.
    assign w_gen_word = bus.in_op ? bus.in_data : w_enc_word;

    secded_syndrome_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_syndrome_gen (
        .i_word     (w_gen_word),
        .o_syndrome (w_syndrome),
        .o_xor_all  (w_xor_all)
    );

    // Stage-1 occupancy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= bus.in_valid;
        end
    end

    // Stage-1 payload; the valid flag alone qualifies it.
    // NOTE: datapath registers carry no reset -- nothing reads them until the valid bit ahead of them is set.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_s1_op   <= bus.in_op;
            r_s1_word <= w_gen_word;
            r_s1_syn  <= w_syndrome;
            r_s1_xor  <= w_xor_all;
        end
    end

    // Encode: drop the check bits into their slots and close with overall parity.
    always_comb begin
        w_enc_cw = r_s1_word;
        for (int i = 0; i < R; i++) begin
            w_enc_cw[(1 << i) - 1] = r_s1_syn[i];
        end
        w_enc_cw[CW-1] = r_s1_xor ^ (^r_s1_syn);
    end

    // Decode: classify from syndrome and overall-parity mismatch.
    always_comb begin
        if (r_s1_syn == '0) begin
            w_class = r_s1_xor ? CORR : NONE;
        end else if (r_s1_xor && (r_s1_syn <= KR_SYN)) begin
            w_class = CORR;
        end else begin
            w_class = UNCORR;
        end
    end

    // Decode: pull the payload out, flipping the one bit the syndrome points at.
    always_comb begin
        w_dec_data = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            w_dec_data[j] = r_s1_word[ecc_data_pos(j)-1]
                          ^ ((w_class == CORR) && (r_s1_syn == R'(ecc_data_pos(j))));
        end
    end

    // Select the stage-2 result word; decode results are zero-extended.
    always_comb begin
        w_s2_data = w_enc_cw;
        if (r_s1_op) begin
            w_s2_data                 = '0;
            w_s2_data[DATA_WIDTH-1:0] = w_dec_data;
        end
    end

    // Stage-2 output registers, frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_op     <= 1'b0;
            r_out_data   <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid  <= r_s1_valid;
            r_out_op     <= r_s1_op;
            r_out_data   <= w_s2_data;
            r_out_corr   <= r_s1_op && (w_class == CORR);
            r_out_uncorr <= r_s1_op && (w_class == UNCORR);
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_op         = r_out_op;
    assign bus.out_data       = r_out_data;
    assign bus.out_err_corr   = r_out_corr;
    assign bus.out_err_uncorr = r_out_uncorr;

`ifdef ECC_ERR_COUNTERS_EN
    logic                 w_deliver_dec;
    logic [CNT_WIDTH-1:0] r_corr_cnt;
    logic [CNT_WIDTH-1:0] r_uncorr_cnt;

    assign w_deliver_dec = r_out_valid & bus.out_ready & r_out_op;

    // Saturating error counters, bumped once per delivered decode beat; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_deliver_dec) begin
            if (r_out_corr && (r_corr_cnt != '1))     r_corr_cnt   <= r_corr_cnt + 1'b1;
            if (r_out_uncorr && (r_uncorr_cnt != '1)) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign corr_cnt         = '0;
    assign uncorr_cnt       = '0;
`endif

endmodule

// File: tb/tb_extended_hamming_stream_codec.sv
// tb_extended_hamming_stream_codec: scoreboard bench for the SECDED stream codec
// (DATA_WIDTH=8, CNT_WIDTH=2). Expected beats are queued when driven and checked
// by a monitor as they are delivered; each scenario task adds its own checks.
module tb_extended_hamming_stream_codec;

    localparam int K  = 8;
    localparam int CW = 13;
    localparam int CN = 2;

    typedef struct packed {
        logic          op;
        logic [CW-1:0] data;
        logic          corr;
        logic          uncorr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnt_clr;
    logic [CN-1:0] corr_cnt;
    logic [CN-1:0] uncorr_cnt;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   delivered = 0;

    extended_hamming_stream_codec_if #(.DATA_WIDTH(K)) bus ();

    extended_hamming_stream_codec #(
        .DATA_WIDTH (K),
        .CNT_WIDTH  (CN)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    // Hamming position of payload bit j for K=8.
    function automatic int dpos(input int j);
        case (j)
            0: return 3;
            1: return 5;
            2: return 6;
            3: return 7;
            4: return 9;
            5: return 10;
            6: return 11;
            7: return 12;
            default: return 0;
        endcase
    endfunction

    function automatic logic [CW-1:0] model_encode(input logic [K-1:0] d);
        logic [CW-1:0] cw;
        logic          p;
        cw = '0;
        for (int j = 0; j < K; j++) cw[dpos(j)-1] = d[j];
        for (int i = 0; i < 4; i++) begin
            p = 1'b0;
            for (int j = 0; j < K; j++) if ((dpos(j) & (1 << i)) != 0) p = p ^ d[j];
            cw[(1 << i) - 1] = p;
        end
        cw[CW-1] = ^cw[CW-2:0];
        return cw;
    endfunction

    function automatic logic [K-1:0] model_extract(input logic [CW-1:0] cw);
        logic [K-1:0] d;
        for (int j = 0; j < K; j++) d[j] = cw[dpos(j)-1];
        return d;
    endfunction

    function automatic exp_t mk(input logic op, input logic [CW-1:0] data,
                                input logic corr, input logic uncorr);
        exp_t e;
        e.op     = op;
        e.data   = data;
        e.corr   = corr;
        e.uncorr = uncorr;
        return e;
    endfunction

    // Scoreboard monitor: every delivered beat must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            total_cnt++;
            delivered++;
            if (sb_q.size() == 0) begin
                $display("FAIL stale_beat: got op=%0b data=%h, expected no beat", bus.out_op, bus.out_data);
            end else begin
                e = sb_q.pop_front();
                if (bus.out_op !== e.op || bus.out_data !== e.data ||
                    bus.out_err_corr !== e.corr || bus.out_err_uncorr !== e.uncorr)
                    $display("FAIL beat_%0d: got op=%0b data=%h corr=%0b uncorr=%0b, expected op=%0b data=%h corr=%0b uncorr=%0b",
                             delivered, bus.out_op, bus.out_data, bus.out_err_corr, bus.out_err_uncorr,
                             e.op, e.data, e.corr, e.uncorr);
                else
                    pass_cnt++;
            end
        end
    end

    // Present one beat (called #1 after a rising edge), wait for acceptance.
    task automatic send(input logic op, input logic [CW-1:0] data, input exp_t e);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        sb_q.push_back(e);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready=%0b after 50 cycles, expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
        total_cnt++;
        if (sb_q.size() != 0) $display("FAIL drain: %0d beats outstanding, expected 0", sb_q.size());
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        cnt_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_op !== 1'b0) $display("FAIL reset_valid_op: got %0b/%0b, expected 0/0", bus.out_valid, bus.out_op);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== '0) $display("FAIL reset_data: got %h, expected 0", bus.out_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_err_corr !== 1'b0 || bus.out_err_uncorr !== 1'b0) $display("FAIL reset_flags: got %0b/%0b, expected 0/0", bus.out_err_corr, bus.out_err_uncorr);
        else pass_cnt++;
        total_cnt++;
        if (corr_cnt !== '0 || uncorr_cnt !== '0) $display("FAIL reset_counters: got %0d/%0d, expected 0/0", corr_cnt, uncorr_cnt);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, expected 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_encode_latency();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_data  = 13'h1FA5;
        sb_q.push_back(mk(1'b0, model_encode(8'hA5), 1'b0, 1'b0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL latency_early: out_valid=%0b one cycle after accept, expected 0", bus.out_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 13'h0A27 || bus.out_err_corr !== 1'b0 || bus.out_err_uncorr !== 1'b0)
            $display("FAIL encode_a5: got valid=%0b data=%h corr=%0b uncorr=%0b, expected 1/0a27/0/0",
                     bus.out_valid, bus.out_data, bus.out_err_corr, bus.out_err_uncorr);
        else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_decode_vectors();
        send(1'b1, 13'h0A37, mk(1'b1, 13'h00A5, 1'b1, 1'b0));
        send(1'b1, 13'h1A27, mk(1'b1, 13'h00A5, 1'b1, 1'b0));
        send(1'b1, 13'h0A24, mk(1'b1, {5'd0, model_extract(13'h0A24)}, 1'b0, 1'b1));
        send(1'b1, 13'h0A27, mk(1'b1, 13'h00A5, 1'b0, 1'b0));
        wait_drain();
    endtask

    task automatic test_random_mix();
        logic [K-1:0]  d;
        logic [CW-1:0] cw;
        int            kind;
        int            b1;
        int            b2;
        for (int n = 0; n < 24; n++) begin
            d = K'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                send(1'b0, {5'($urandom), d}, mk(1'b0, model_encode(d), 1'b0, 1'b0));
            end else begin
                cw   = model_encode(d);
                kind = $urandom_range(0, 2);
                b1   = $urandom_range(0, CW - 1);
                b2   = (b1 + $urandom_range(1, CW - 1)) % CW;
                if (kind == 0) begin
                    send(1'b1, cw, mk(1'b1, {5'd0, d}, 1'b0, 1'b0));
                end else if (kind == 1) begin
                    cw[b1] = ~cw[b1];
                    send(1'b1, cw, mk(1'b1, {5'd0, d}, 1'b1, 1'b0));
                end else begin
                    cw[b1] = ~cw[b1];
                    cw[b2] = ~cw[b2];
                    send(1'b1, cw, mk(1'b1, {5'd0, model_extract(cw)}, 1'b0, 1'b1));
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int            base;
        logic [CW-1:0] held;
        logic [K-1:0]  d;
        logic [CW-1:0] cw;
        base = delivered;
        held = '0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d = K'(i * 29 + 7);
                    if (i % 2 == 0) begin
                        send(1'b0, {5'd0, d}, mk(1'b0, model_encode(d), 1'b0, 1'b0));
                    end else begin
                        cw    = model_encode(d);
                        cw[i] = ~cw[i];
                        send(1'b1, cw, mk(1'b1, {5'd0, d}, 1'b1, 1'b0));
                    end
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    if (c == 0) held = bus.out_data;
                    total_cnt++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== held)
                        $display("FAIL stall_cycle_%0d: in_ready=%0b out_valid=%0b data=%h, expected 0/1/%h",
                                 c + 3, bus.in_ready, bus.out_valid, bus.out_data, held);
                    else pass_cnt++;
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        total_cnt++;
        if (delivered - base != 8) $display("FAIL b2b_count: delivered %0d, expected 8", delivered - base);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        int snap;
        @(posedge clk);
        #1;
        send(1'b0, 13'h0011, mk(1'b0, model_encode(8'h11), 1'b0, 1'b0));
        send(1'b0, 13'h0022, mk(1'b0, model_encode(8'h22), 1'b0, 1'b0));
        rst = 1'b1;
        sb_q.delete();
        snap = delivered;
        @(posedge clk);
        #1;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL midreset_valid: got %0b, expected 0", bus.out_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %0b, expected 1", bus.in_ready);
        else pass_cnt++;
        repeat (6) @(negedge clk);
        total_cnt++;
        if (delivered != snap) $display("FAIL midreset_stale: %0d beats emerged, expected 0", delivered - snap);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_counters();
        bit ok;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int n = 0; n < 5; n++) send(1'b1, 13'h0A37, mk(1'b1, 13'h00A5, 1'b1, 1'b0));
        send(1'b0, 13'h00A5, mk(1'b0, 13'h0A27, 1'b0, 1'b0));
        send(1'b1, 13'h0A24, mk(1'b1, 13'h00A5, 1'b0, 1'b1));
        wait_drain();
        @(negedge clk);
`ifdef ECC_ERR_COUNTERS_EN
        total_cnt++;
        if (corr_cnt !== 2'd3 || uncorr_cnt !== 2'd1) $display("FAIL cnt_saturate: got corr=%0d uncorr=%0d, expected 3/1", corr_cnt, uncorr_cnt);
        else pass_cnt++;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(1'b1, 13'h0A37, mk(1'b1, 13'h00A5, 1'b1, 1'b0));
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b1;
        end
        total_cnt++;
        if (!ok) $display("FAIL cnt_wait_valid: out_valid=%0b, expected 1", bus.out_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        cnt_clr       = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) $display("FAIL cnt_clear_wins: got corr=%0d uncorr=%0d, expected 0/0", corr_cnt, uncorr_cnt);
        else pass_cnt++;
`else
        ok = 1'b1;
        total_cnt++;
        if (!ok || corr_cnt !== '0 || uncorr_cnt !== '0) $display("FAIL cnt_tied_off: got corr=%0d uncorr=%0d, expected 0/0", corr_cnt, uncorr_cnt);
        else pass_cnt++;
`endif
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_encode_latency();
        test_decode_vectors();
        test_random_mix();
        test_back_to_back();
        test_reset_midstream();
        test_counters();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard time limit so a wedged handshake can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
